rs232_cmd_dispatch: RTL and testbench
=====================================

Name: rs232_cmd_dispatch

Overview:
- Sequencer behind the rs232_if command/response FIFOs.
- Pops 32-bit command words from the command FIFO and decodes them into single register-bus read/write transactions.
- Pushes one 32-bit response word per non-NOP command into the response FIFO.
- Owns the only register-bus master port on the serial-comm side of the design.

Parameters:
TIMEOUT_CYCLES, 255, ACCESS cycles to wait for reg_ack before aborting (1..65535)
ADDR_W, 8, register-bus address width (fixed field width in command word)
DATA_W, 16, register-bus data width (fixed field width in command word)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
cmd_fifo_dout  in  32  command word; valid the cycle after a rd_en cycle (standard, non-FWFT FIFO)
cmd_fifo_empty  in  1  command FIFO empty
cmd_fifo_rd_en  out  1  command FIFO pop, registered
rsp_fifo_din  out  32  response word, registered
rsp_fifo_wr_en  out  1  response FIFO push, registered
rsp_fifo_full  in  1  response FIFO full
reg_addr  out  8  register-bus address
reg_wdata  out  16  register-bus write data
reg_wr  out  1  write strobe, one-cycle pulse
reg_rd  out  1  read strobe, one-cycle pulse
reg_rdata  in  16  read data, valid when reg_ack=1
reg_ack  in  1  transaction complete
busy  out  1  high in any state except IDLE
err_count  out  8  saturating count of error responses

Behaviour:
- Command word fields:
  - [31:28] op: 0x0 NOP, 0x1 WRITE, 0x2 READ, others illegal.
  - [27:24] ignored.
  - [23:16] addr.
  - [15:0] data.
- Response word: {op[3:0], status[3:0], addr[7:0], data[15:0]}.
  - status: 0 OK, 1 TIMEOUT, 2 BAD_OP.
  - data: reg_rdata for READ OK; the command data for WRITE; 0 for TIMEOUT and BAD_OP.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; all outputs go to 0; err_count clears.
  - Any in-flight command is dropped with no response.
- States and transitions:
  - IDLE: when cmd_fifo_empty=0, go to FETCH.
  - FETCH: cmd_fifo_rd_en=1 for exactly this one cycle, then go to DECODE.
  - DECODE: latch cmd_fifo_dout into the command register at the end of the cycle, then:
    - NOP -> IDLE.
    - WRITE/READ -> ACCESS.
    - illegal -> RESP_WAIT with status 2.
  - ACCESS, first cycle:
    - reg_addr/reg_wdata are driven from the command register.
    - reg_wr (WRITE) or reg_rd (READ) pulses for exactly one cycle.
    - reg_addr/reg_wdata are held stable until ACCESS exits.
  - ACCESS, ack handling:
    - reg_ack is sampled every ACCESS cycle, including the strobe cycle.
    - On ack: capture reg_rdata (READ), status 0, go to RESP_WAIT.
    - The timeout counter starts at 0 on entry and increments per ACCESS cycle without ack.
    - When the counter reaches TIMEOUT_CYCLES-1 without ack: status 1, go to RESP_WAIT.
    - Ack arriving in that same final cycle wins (status 0).
    - Ack arriving after exit is ignored.
  - RESP_WAIT:
    - Build rsp_fifo_din.
    - If rsp_fifo_full=0, go to RESP; otherwise stall indefinitely with no push and no further pops.
  - RESP:
    - rsp_fifo_wr_en=1 for exactly one cycle, with rsp_fifo_din stable in that cycle.
    - err_count increments (saturating at 255) if status!=0.
    - Go to IDLE.
- Throughput:
  - At most one command outstanding; no pop occurs while busy.
  - Minimum loop is 5 cycles per WRITE/READ with ack in the strobe cycle (FETCH, DECODE, ACCESS, RESP_WAIT, RESP), plus 1 IDLE cycle before the next FETCH.
  - NOP: 3 cycles (IDLE, FETCH, DECODE).
- Boundaries:
  - cmd_fifo_empty rising in the same cycle it is sampled low in IDLE: FETCH still proceeds; the FIFO guarantees the word.
  - reg_ack asserted outside ACCESS: ignored.
  - rsp_fifo_full toggling during RESP_WAIT: sampled each cycle.
  - err_count holds at 255.

Test Plan:
- WRITE: cmd word 0x1000_3A5C, reg_ack on the 3rd ACCESS cycle -> reg_wr one-cycle pulse with reg_addr=0x00, reg_wdata=0x3A5C; response 0x1000_3A5C; err_count=0.
- READ: cmd 0x2012_0000, reg_ack with reg_rdata=0xBEEF in the strobe cycle -> reg_rd pulse with reg_addr=0x12; response 0x2012_BEEF.
- Timeout: cmd 0x2034_0000, never ack, TIMEOUT_CYCLES=8 -> exactly 8 ACCESS cycles; response 0x2134_0000; err_count=1; a late ack is ignored.
- Illegal + NOP: cmds 0x7055_1234 then 0x0000_0000 -> one response 0x7255_0000, no bus strobes, NOP gives no response; err_count=1; NOP pop completes 3 cycles after IDLE.
- Backpressure: rsp_fifo_full=1 for 20 cycles with 2 queued WRITEs -> first response held, single wr_en after full drops, second cmd not popped until then; both responses in order.
- Reset mid-ACCESS: rst asserted during a pending READ -> all outputs 0 immediately (async); after release the remaining queued cmd is processed normally and no response is produced for the aborted one.

Source files
------------

// File: rtl/rs232_cmd_dispatch.sv
// Command sequencer between the rs232 command/response FIFOs and the register bus.
// Runs one command at a time: fetch, decode, one bus access, then one response word.
module rs232_cmd_dispatch #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cmd_fifo_dout,
    input  logic              cmd_fifo_empty,
    output logic              cmd_fifo_rd_en,
    output logic [31:0]       rsp_fifo_din,
    output logic              rsp_fifo_wr_en,
    input  logic              rsp_fifo_full,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam logic [3:0]  OP_NOP     = 4'h0;
    localparam logic [3:0]  OP_WRITE   = 4'h1;
    localparam logic [3:0]  OP_READ    = 4'h2;
    localparam logic [3:0]  ST_OK      = 4'h0;
    localparam logic [3:0]  ST_TIMEOUT = 4'h1;
    localparam logic [3:0]  ST_BAD_OP  = 4'h2;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ACCESS,
        S_RESP_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_rd_en;
    logic                r_wr_en;
    logic [31:0]         r_din;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr;
    logic                r_rd;
    logic                r_busy;
    logic [7:0]          r_err;
    logic [3:0]          r_op;
    logic [3:0]          r_status;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_data;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [15:0]         r_timer;

    logic [3:0]          w_op;
    logic                w_unused;

    assign w_op     = cmd_fifo_dout[31:28];
    assign w_unused = ^cmd_fifo_dout[27:24];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= '0;
            r_op       <= '0;
            r_status   <= '0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
            r_rsp_data <= '0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!cmd_fifo_empty) begin
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    // FIFO word is valid now, one cycle after the pop
                    r_op       <= w_op;
                    r_cmd_addr <= cmd_fifo_dout[23:16];
                    r_cmd_data <= cmd_fifo_dout[15:0];
                    r_timer    <= '0;
                    case (w_op)
                        OP_NOP: begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                        OP_WRITE, OP_READ: begin
                            r_addr  <= cmd_fifo_dout[23:16];
                            r_wdata <= cmd_fifo_dout[15:0];
                            r_wr    <= (w_op == OP_WRITE);
                            r_rd    <= (w_op == OP_READ);
                            r_state <= S_ACCESS;
                        end
                        default: begin
                            r_status   <= ST_BAD_OP;
                            r_rsp_data <= '0;
                            r_state    <= S_RESP_WAIT;
                        end
                    endcase
                end
                S_ACCESS: begin
                    r_wr <= 1'b0;
                    r_rd <= 1'b0;
                    // ack takes priority over the timeout in the final cycle
                    if (reg_ack) begin
                        r_status   <= ST_OK;
                        r_rsp_data <= (r_op == OP_READ) ? reg_rdata : r_cmd_data;
                        r_state    <= S_RESP_WAIT;
                    end else if (r_timer == TIMER_LAST) begin
                        r_status   <= ST_TIMEOUT;
                        r_rsp_data <= '0;
                        r_state    <= S_RESP_WAIT;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_RESP_WAIT: begin
                    r_din <= {r_op, r_status, r_cmd_addr, r_rsp_data};
                    if (!rsp_fifo_full) begin
                        r_wr_en <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_wr_en <= 1'b0;
                    if (r_status != ST_OK) r_err <= sat_inc8(r_err);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_fifo_rd_en = r_rd_en;
    assign rsp_fifo_din   = r_din;
    assign rsp_fifo_wr_en = r_wr_en;
    assign reg_addr       = r_addr;
    assign reg_wdata      = r_wdata;
    assign reg_wr         = r_wr;
    assign reg_rd         = r_rd;
    assign busy           = r_busy;
    assign err_count      = r_err;

endmodule

// File: tb/tb_rs232_cmd_dispatch.sv
// Directed bench for rs232_cmd_dispatch: FIFO and register-bus models around the DUT,
// hand-computed response words and cycle offsets.
module tb_rs232_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_fifo_dout;
    logic        cmd_fifo_empty;
    logic        cmd_fifo_rd_en;
    logic [31:0] rsp_fifo_din;
    logic        rsp_fifo_wr_en;
    logic        rsp_fifo_full;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        reg_ack;
    logic        busy;
    logic [7:0]  err_count;

    rs232_cmd_dispatch #(.TIMEOUT_CYCLES(8), .ADDR_W(8), .DATA_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_fifo_dout  (cmd_fifo_dout),
        .cmd_fifo_empty (cmd_fifo_empty),
        .cmd_fifo_rd_en (cmd_fifo_rd_en),
        .rsp_fifo_din   (rsp_fifo_din),
        .rsp_fifo_wr_en (rsp_fifo_wr_en),
        .rsp_fifo_full  (rsp_fifo_full),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_wr         (reg_wr),
        .reg_rd         (reg_rd),
        .reg_rdata      (reg_rdata),
        .reg_ack        (reg_ack),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO model (standard read latency of one cycle)
    logic [31:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign cmd_fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (cmd_fifo_rd_en && (rd_ptr != wr_ptr)) begin
            cmd_fifo_dout <= mem[rd_ptr % 32];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Register-bus responder: ack lands ack_delay cycles after the strobe cycle
    int          ack_delay = 0;
    int          acc_cnt   = 0;
    bit          pend      = 0;
    bit          stray_ack = 0;
    logic [15:0] rdata_val = '0;
    always @(negedge clk) begin
        if (reg_wr || reg_rd) begin
            acc_cnt = 0;
            pend    = 1;
        end else if (pend) begin
            acc_cnt++;
        end
        reg_ack   = (pend && acc_cnt == ack_delay) || stray_ack;
        if (pend && acc_cnt == ack_delay) pend = 0;
        reg_rdata = rdata_val;
    end

    // Observation log
    int          n_wr = 0, n_rd = 0, n_rsp = 0, n_pop = 0, n_long = 0;
    int          wr_cyc, rd_cyc;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [31:0] rsp_log [0:31];
    int          rsp_cyc [0:31];
    int          pop_cyc [0:31];
    bit          p_wr = 0, p_rd = 0, p_we = 0, p_re = 0;
    always @(negedge clk) begin
        if (reg_wr) begin n_wr++; wr_cyc = cyc; wr_addr = reg_addr; wr_data = reg_wdata; end
        if (reg_rd) begin n_rd++; rd_cyc = cyc; rd_addr = reg_addr; end
        if (rsp_fifo_wr_en) begin rsp_log[n_rsp % 32] = rsp_fifo_din; rsp_cyc[n_rsp % 32] = cyc; n_rsp++; end
        if (cmd_fifo_rd_en) begin pop_cyc[n_pop % 32] = cyc; n_pop++; end
        if ((reg_wr && p_wr) || (reg_rd && p_rd) || (rsp_fifo_wr_en && p_we) || (cmd_fifo_rd_en && p_re))
            n_long++;
        p_wr = reg_wr; p_rd = reg_rd; p_we = rsp_fifo_wr_en; p_re = cmd_fifo_rd_en;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rsp(input string tag, input int n, input int budget);
        int k = 0;
        while (n_rsp < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_rsp, n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1);
    end

    int base_wr, base_rd, base_rsp, base_pop, k;

    initial begin
        rst = 1'b1;
        rsp_fifo_full = 1'b0;
        idle(2);
        chk("reset_outputs", {cmd_fifo_rd_en, rsp_fifo_wr_en, reg_wr, reg_rd, busy}, 0);
        chk("reset_bus", {reg_addr, reg_wdata, err_count}, 0);
        chk("reset_din", rsp_fifo_din, 0);
        rst = 1'b0;
        idle(2);

        // WRITE, ack on the third ACCESS cycle
        ack_delay = 2;
        push(32'h1000_3A5C);
        wait_rsp("write_rsp_count", 1, 40);
        chk("write_strobes", {n_wr[7:0], n_rd[7:0]}, {8'd1, 8'd0});
        chk("write_addr", wr_addr, 8'h00);
        chk("write_data", wr_data, 16'h3A5C);
        chk("write_rsp", rsp_log[0], 32'h1000_3A5C);
        chk("write_strobe_lat", wr_cyc - pop_cyc[0], 2);
        chk("write_rsp_lat", rsp_cyc[0] - wr_cyc, 4);
        idle(2);
        chk("write_err", err_count, 0);
        chk("write_idle_busy", busy, 0);

        // READ, ack in the strobe cycle
        ack_delay = 0;
        rdata_val = 16'hBEEF;
        push(32'h2012_0000);
        wait_rsp("read_rsp_count", 2, 40);
        chk("read_strobes", {n_wr[7:0], n_rd[7:0]}, {8'd1, 8'd1});
        chk("read_addr", rd_addr, 8'h12);
        chk("read_rsp", rsp_log[1], 32'h2012_BEEF);
        chk("read_rsp_lat", rsp_cyc[1] - rd_cyc, 2);
        idle(2);

        // Timeout: ack arrives one cycle after the 8th ACCESS cycle
        ack_delay = 8;
        rdata_val = 16'h5555;
        push(32'h2034_0000);
        wait_rsp("tmo_rsp_count", 3, 60);
        chk("tmo_rsp", rsp_log[2], 32'h2134_0000);
        chk("tmo_rsp_lat", rsp_cyc[2] - rd_cyc, 9);
        idle(2);
        chk("tmo_err", err_count, 1);

        // Ack in the final allowed ACCESS cycle still counts
        ack_delay = 7;
        rdata_val = 16'h1234;
        push(32'h2040_0000);
        wait_rsp("last_ack_rsp_count", 4, 60);
        chk("last_ack_rsp", rsp_log[3], 32'h2040_1234);
        chk("last_ack_lat", rsp_cyc[3] - rd_cyc, 9);
        idle(2);
        chk("last_ack_err", err_count, 1);

        // Stray ack while idle
        stray_ack = 1;
        idle(4);
        stray_ack = 0;
        idle(1);
        chk("stray_ack_rsp", n_rsp, 4);
        chk("stray_ack_busy", busy, 0);

        // Illegal opcode followed by a NOP
        ack_delay = 0;
        base_wr = n_wr; base_rd = n_rd; base_pop = n_pop;
        push(32'h7055_1234);
        push(32'h0000_0000);
        wait_rsp("bad_rsp_count", 5, 40);
        chk("bad_rsp", rsp_log[4], 32'h7255_0000);
        chk("bad_rsp_lat", rsp_cyc[4] - pop_cyc[base_pop % 32], 3);
        k = 0;
        while (n_pop < base_pop + 2 && k < 20) begin @(negedge clk); k++; end
        chk("nop_popped", n_pop, base_pop + 2);
        chk("nop_pop_lat", pop_cyc[(base_pop + 1) % 32] - rsp_cyc[4], 2);
        idle(6);
        chk("nop_no_rsp", n_rsp, 5);
        chk("bad_no_strobe", {n_wr[7:0], n_rd[7:0]}, {base_wr[7:0], base_rd[7:0]});
        chk("bad_err", err_count, 2);
        chk("nop_busy", busy, 0);

        // Backpressure with two queued WRITEs
        base_pop = n_pop;
        rsp_fifo_full = 1'b1;
        push(32'h1001_1111);
        push(32'h1002_2222);
        idle(20);
        chk("bp_held_rsp", n_rsp, 5);
        chk("bp_single_pop", n_pop, base_pop + 1);
        chk("bp_busy", busy, 1);
        rsp_fifo_full = 1'b0;
        wait_rsp("bp_rsp_count", 7, 60);
        chk("bp_rsp0", rsp_log[5], 32'h1001_1111);
        chk("bp_rsp1", rsp_log[6], 32'h1002_2222);
        chk("bp_second_pop", pop_cyc[(base_pop + 1) % 32] - rsp_cyc[5], 2);
        idle(3);

        // Asynchronous reset during a pending READ
        ack_delay = -1;
        push(32'h2066_0000);
        push(32'h1077_5555);
        k = 0;
        while (!reg_rd && k < 30) begin @(negedge clk); k++; end
        chk("rst_saw_read", reg_rd, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_ctl", {cmd_fifo_rd_en, rsp_fifo_wr_en, reg_wr, reg_rd, busy}, 0);
        chk("rst_async_bus", {reg_addr, reg_wdata, err_count}, 0);
        chk("rst_async_din", rsp_fifo_din, 0);
        idle(2);
        base_rd = n_rd; base_wr = n_wr;
        ack_delay = 0;
        rst = 1'b0;
        wait_rsp("rst_rsp_count", 8, 40);
        chk("rst_rsp", rsp_log[7], 32'h1077_5555);
        idle(10);
        chk("rst_no_extra_rsp", n_rsp, 8);
        chk("rst_strobes", {n_wr[7:0], n_rd[7:0]}, {base_wr[7:0] + 8'd1, base_rd[7:0]});
        chk("rst_err", err_count, 0);
        chk("pulse_widths", n_long, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
